// File: rtl/logic_op_rmw_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// logic_op_rmw_ctrl_pkg
//   Shared definitions for the LogicOp read-modify-write sequencer:
//   - 4-bit logic-op codes, CLEAR (0) through OR_INVERTED (15)
//   - FSM state encoding
//   - a helper that decides whether an op needs the destination pixel
// ---------------------------------------------------------------------------
package logic_op_rmw_ctrl_pkg;

  // Logic-op codes. The four ops that ignore the destination occupy
  // codes 0..3, so "needs dest" reduces to a simple compare.
  localparam logic [3:0] OP_CLEAR         = 4'd0;
  localparam logic [3:0] OP_SET           = 4'd1;
  localparam logic [3:0] OP_COPY          = 4'd2;
  localparam logic [3:0] OP_COPY_INVERTED = 4'd3;
  localparam logic [3:0] OP_NOOP          = 4'd4;
  localparam logic [3:0] OP_INVERT        = 4'd5;
  localparam logic [3:0] OP_AND           = 4'd6;
  localparam logic [3:0] OP_NAND          = 4'd7;
  localparam logic [3:0] OP_OR            = 4'd8;
  localparam logic [3:0] OP_NOR           = 4'd9;
  localparam logic [3:0] OP_XOR           = 4'd10;
  localparam logic [3:0] OP_EQUIV         = 4'd11;
  localparam logic [3:0] OP_AND_REVERSE   = 4'd12; // s & ~d
  localparam logic [3:0] OP_AND_INVERTED  = 4'd13; // ~s & d
  localparam logic [3:0] OP_OR_REVERSE    = 4'd14; // s | ~d
  localparam logic [3:0] OP_OR_INVERTED   = 4'd15; // ~s | d

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READ_REQ = 3'd1;
  localparam logic [2:0] ST_WAIT_RSP = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;

  // With the op disabled the source passes straight through, so no read.
  function automatic logic op_needs_dest(input logic [3:0] op, input logic enable);
    return enable && (op > OP_COPY_INVERTED);
  endfunction

endpackage

// File: rtl/logic_op_rmw_ctrl_if.sv
// ---------------------------------------------------------------------------
// logic_op_rmw_ctrl_if
//   Bundles the three handshake buses of the sequencer:
//   - s_*      fragment input       (valid/ready)
//   - rd_req_* dest read request    (valid/ready)
//   - rd_rsp_* dest read response   (valid only, no backpressure)
//   - m_*      colour-buffer write  (valid/ready)
//   Handshake rule: a transfer happens on a rising edge where valid and ready
//   are both high; once valid is raised, the payload is held stable until
//   that transfer.
//   Modports: slave = the sequencer, master = the surrounding system.
// ---------------------------------------------------------------------------
interface logic_op_rmw_ctrl_if #(
  parameter int PIXEL_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic [ADDR_WIDTH-1:0]  s_addr;
  logic [PIXEL_WIDTH-1:0] s_pixel;

  logic                   rd_req_valid;
  logic                   rd_req_ready;
  logic [ADDR_WIDTH-1:0]  rd_req_addr;

  logic                   rd_rsp_valid;
  logic [PIXEL_WIDTH-1:0] rd_rsp_data;

  logic                   m_valid;
  logic                   m_ready;
  logic [ADDR_WIDTH-1:0]  m_addr;
  logic [PIXEL_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_addr, s_pixel, rd_req_ready, rd_rsp_valid, rd_rsp_data, m_ready,
    output s_ready, rd_req_valid, rd_req_addr, m_valid, m_addr, m_data
  );

  modport master (
    output s_valid, s_addr, s_pixel, rd_req_ready, rd_rsp_valid, rd_rsp_data, m_ready,
    input  s_ready, rd_req_valid, rd_req_addr, m_valid, m_addr, m_data
  );
endinterface

// File: rtl/logic_op_rmw_ctrl_logic_op.sv
// ---------------------------------------------------------------------------
// logic_op_rmw_ctrl_logic_op
//   LogicOp pixel stage. Combines source and destination with the selected
//   op and registers the result on a clock-enable cycle.
//   Ports:
//     aclk, reset  clock, synchronous active-high reset
//     i_ce         register the result this cycle
//     i_enable     0: result = source (op bypassed)
//     i_op         4-bit op code
//     i_src/i_dst  source / destination pixels
//     o_result     registered result
// ---------------------------------------------------------------------------
module logic_op_rmw_ctrl_logic_op
  import logic_op_rmw_ctrl_pkg::*;
#(
  parameter int PIXEL_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic                   i_ce,
  input  logic                   i_enable,
  input  logic [3:0]             i_op,
  input  logic [PIXEL_WIDTH-1:0] i_src,
  input  logic [PIXEL_WIDTH-1:0] i_dst,
  output logic [PIXEL_WIDTH-1:0] o_result
);
  logic [PIXEL_WIDTH-1:0] w_op_out;
  logic [PIXEL_WIDTH-1:0] r_result;

  always_comb begin
    w_op_out = '0;
    case (i_op)
      OP_CLEAR:         w_op_out = '0;
      OP_SET:           w_op_out = '1;
      OP_COPY:          w_op_out = i_src;
      OP_COPY_INVERTED: w_op_out = ~i_src;
      OP_NOOP:          w_op_out = i_dst;
      OP_INVERT:        w_op_out = ~i_dst;
      OP_AND:           w_op_out = i_src & i_dst;
      OP_NAND:          w_op_out = ~(i_src & i_dst);
      OP_OR:            w_op_out = i_src | i_dst;
      OP_NOR:           w_op_out = ~(i_src | i_dst);
      OP_XOR:           w_op_out = i_src ^ i_dst;
      OP_EQUIV:         w_op_out = ~(i_src ^ i_dst);
      OP_AND_REVERSE:   w_op_out = i_src & ~i_dst;
      OP_AND_INVERTED:  w_op_out = ~i_src & i_dst;
      OP_OR_REVERSE:    w_op_out = i_src | ~i_dst;
      OP_OR_INVERTED:   w_op_out = ~i_src | i_dst;
      default:          w_op_out = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_result <= '0;
    end else if (i_ce) begin
      r_result <= i_enable ? w_op_out : i_src;
    end
  end

  assign o_result = r_result;
endmodule

// File: rtl/logic_op_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// logic_op_rmw_ctrl
//   Read-modify-write sequencer around the LogicOp stage. Takes one fragment
//   at a time, reads the destination pixel only when the op needs it, runs
//   LogicOp for one clock-enable cycle and writes the result back.
//   Ports:
//     aclk, reset          clock, synchronous active-high reset
//     conf_op, conf_enable op config, sampled when a fragment is accepted
//     bus                  fragment / dest-read / write handshakes (slave)
//     busy                 high whenever the FSM is not idle
//     err_rsp              sticky: read response seen outside WAIT_RSP
//     frag_count           completed writes, wraps at 2^32
//     o_dbg_state          current FSM state
// ---------------------------------------------------------------------------
module logic_op_rmw_ctrl
  import logic_op_rmw_ctrl_pkg::*;
#(
  parameter int PIXEL_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [3:0]  conf_op,
  input  logic        conf_enable,
  logic_op_rmw_ctrl_if.slave bus,
  output logic        busy,
  output logic        err_rsp,
  output logic [31:0] frag_count,
  output logic [2:0]  o_dbg_state
);
  logic [2:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [PIXEL_WIDTH-1:0] r_src;
  logic [PIXEL_WIDTH-1:0] r_dest;
  logic [3:0]             r_op;
  logic                   r_en;
  logic                   r_err;
  logic [31:0]            r_count;
  logic                   w_ce;
  logic [PIXEL_WIDTH-1:0] w_result;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_src   <= '0;
      r_dest  <= '0;
      r_op    <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      // Any response outside WAIT_RSP is dropped and flagged.
      if (bus.rd_rsp_valid && (r_state != ST_WAIT_RSP)) r_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (bus.s_valid) begin
            r_addr  <= bus.s_addr;
            r_src   <= bus.s_pixel;
            r_op    <= conf_op;
            r_en    <= conf_enable;
            r_dest  <= '0;  // skip path: dest unused by these ops
            r_state <= op_needs_dest(conf_op, conf_enable) ? ST_READ_REQ : ST_EXEC;
          end
        end
        ST_READ_REQ: begin
          if (bus.rd_req_ready) r_state <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          if (bus.rd_rsp_valid) begin
            r_dest  <= bus.rd_rsp_data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (bus.m_ready) begin
            r_count <= r_count + 32'd1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_ce = (r_state == ST_EXEC);

  logic_op_rmw_ctrl_logic_op #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_logic_op (
    .aclk     (aclk),
    .reset    (reset),
    .i_ce     (w_ce),
    .i_enable (r_en),
    .i_op     (r_op),
    .i_src    (r_src),
    .i_dst    (r_dest),
    .o_result (w_result)
  );

  assign bus.s_ready      = (r_state == ST_IDLE);
  assign bus.rd_req_valid = (r_state == ST_READ_REQ);
  assign bus.rd_req_addr  = r_addr;
  assign bus.m_valid      = (r_state == ST_WRITE);
  assign bus.m_addr       = r_addr;
  assign bus.m_data       = w_result;
  assign busy             = (r_state != ST_IDLE);
  assign err_rsp          = r_err;
  assign frag_count       = r_count;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_logic_op_rmw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logic_op_rmw_ctrl
//   Directed plus randomized bench for the LogicOp read-modify-write
//   sequencer. Expected results come from a per-bit truth-table model of
//   each logic op; inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_logic_op_rmw_ctrl;
  import logic_op_rmw_ctrl_pkg::*;

  localparam int PW = 32;
  localparam int AW = 16;

  logic          aclk = 1'b0;
  logic          reset;
  logic [3:0]    conf_op;
  logic          conf_enable;
  logic          busy;
  logic          err_rsp;
  logic [31:0]   frag_count;
  logic [2:0]    dbg_state;

  logic_op_rmw_ctrl_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  logic_op_rmw_ctrl #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .conf_op     (conf_op),
    .conf_enable (conf_enable),
    .bus         (bus.slave),
    .busy        (busy),
    .err_rsp     (err_rsp),
    .frag_count  (frag_count),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_count = '0;
  logic        exp_err   = 1'b0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // Truth table per op, index {s,d}: bit3=s1d1 bit2=s1d0 bit1=s0d1 bit0=s0d0.
  function automatic logic [3:0] truth(input logic [3:0] op);
    case (op)
      OP_CLEAR:         return 4'b0000;
      OP_SET:           return 4'b1111;
      OP_COPY:          return 4'b1100;
      OP_COPY_INVERTED: return 4'b0011;
      OP_NOOP:          return 4'b1010;
      OP_INVERT:        return 4'b0101;
      OP_AND:           return 4'b1000;
      OP_NAND:          return 4'b0111;
      OP_OR:            return 4'b1110;
      OP_NOR:           return 4'b0001;
      OP_XOR:           return 4'b0110;
      OP_EQUIV:         return 4'b1001;
      OP_AND_REVERSE:   return 4'b0100;
      OP_AND_INVERTED:  return 4'b0010;
      OP_OR_REVERSE:    return 4'b1101;
      default:          return 4'b1011; // OR_INVERTED
    endcase
  endfunction

  function automatic logic [PW-1:0] model(input logic [3:0] op, input logic en,
                                          input logic [PW-1:0] s, input logic [PW-1:0] d);
    logic [PW-1:0] r;
    logic [3:0]    tt;
    if (!en) return s;
    tt = truth(op);
    for (int b = 0; b < PW; b++) r[b] = tt[{s[b], d[b]}];
    return r;
  endfunction

  function automatic logic model_reads(input logic [3:0] op, input logic en);
    return en && !(op inside {OP_CLEAR, OP_SET, OP_COPY, OP_COPY_INVERTED});
  endfunction

  // ---------------- driver ----------------
  // Starts and ends just after a falling edge with the DUT idle.
  task automatic run_frag(input logic [3:0] op, input logic en, input logic [AW-1:0] addr,
                          input logic [PW-1:0] src, input logic [PW-1:0] dst,
                          input int rstall, input int lat, input int hold);
    logic [PW-1:0] exp_d;
    logic          rd;
    rd = model_reads(op, en);
    chk("idle_s_ready", bus.s_ready, 1);
    chk("idle_busy", busy, 0);
    conf_op = op; conf_enable = en;
    bus.s_valid = 1'b1; bus.s_addr = addr; bus.s_pixel = src;
    exp_q.push_back(model(op, en, src, dst));
    @(negedge aclk);
    // Scramble config and fragment inputs: must not affect this fragment.
    bus.s_valid = 1'b0;
    conf_op = 4'($urandom); conf_enable = 1'($urandom);
    bus.s_addr = AW'($urandom); bus.s_pixel = $urandom;
    chk("after_accept_s_ready", bus.s_ready, 0);
    chk("after_accept_busy", busy, 1);
    if (rd) begin
      chk("rd_req_valid", bus.rd_req_valid, 1);
      chk("rd_req_addr", bus.rd_req_addr, addr);
      for (int i = 0; i < rstall; i++) begin
        @(negedge aclk);
        chk("rd_req_hold_valid", bus.rd_req_valid, 1);
        chk("rd_req_hold_addr", bus.rd_req_addr, addr);
      end
      bus.rd_req_ready = 1'b1;
      @(negedge aclk);
      bus.rd_req_ready = 1'b0;
      chk("wait_rsp_no_req", bus.rd_req_valid, 0);
      for (int i = 0; i < lat; i++) begin
        @(negedge aclk);
        chk("wait_rsp_no_write", bus.m_valid, 0);
        chk("wait_rsp_no_req2", bus.rd_req_valid, 0);
      end
      bus.rd_rsp_valid = 1'b1; bus.rd_rsp_data = dst;
      @(negedge aclk);
      bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = $urandom;
      chk("exec_no_write", bus.m_valid, 0);
    end else begin
      chk("skip_no_req", bus.rd_req_valid, 0);
      chk("exec_no_write", bus.m_valid, 0);
    end
    @(negedge aclk);
    exp_d = exp_q.pop_front();
    chk("write_valid", bus.m_valid, 1);
    chk("write_no_req", bus.rd_req_valid, 0);
    chk("write_addr", bus.m_addr, addr);
    chk("write_data", bus.m_data, exp_d);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_addr", bus.m_addr, addr);
      chk("hold_data", bus.m_data, exp_d);
      chk("hold_s_ready", bus.s_ready, 0);
    end
    bus.m_ready = 1'b1;
    @(negedge aclk);
    bus.m_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    chk("frag_count", frag_count, exp_count);
    chk("done_s_ready", bus.s_ready, 1);
    chk("done_m_valid", bus.m_valid, 0);
    chk("err_rsp", err_rsp, exp_err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    conf_op = '0; conf_enable = 1'b0;
    bus.s_valid = 1'b0; bus.s_addr = '0; bus.s_pixel = '0;
    bus.rd_req_ready = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = '0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge aclk);
    reset = 1'b0;

    // Reset state
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req_valid", bus.rd_req_valid, 0);
    chk("rst_rd_req_addr", bus.rd_req_addr, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_err_rsp", err_rsp, 0);
    chk("rst_frag_count", frag_count, 0);

    // 1: XOR read path, response 3 cycles after the request handshake
    run_frag(OP_XOR, 1'b1, 16'h0010, 32'h00FF00FF, 32'h0F0F0F0F, 0, 3, 0);
    // 2: SET skip path
    run_frag(OP_SET, 1'b1, 16'h0020, 32'h12345678, 32'h0, 0, 0, 0);
    // 3: AND with op disabled passes source through
    run_frag(OP_AND, 1'b0, 16'h0030, 32'hCAFEBABE, 32'h0, 0, 0, 0);
    // 4: NAND read path with write backpressure
    run_frag(OP_NAND, 1'b1, 16'h0040, 32'hF0F0AAAA, 32'hFF00CCCC, 2, 1, 5);

    // 5: spurious response while idle
    bus.rd_rsp_valid = 1'b1; bus.rd_rsp_data = 32'hDEADBEEF;
    @(negedge aclk);
    bus.rd_rsp_valid = 1'b0;
    exp_err = 1'b1;
    chk("spurious_err", err_rsp, 1);
    chk("spurious_idle", bus.s_ready, 1);
    run_frag(OP_OR, 1'b1, 16'h0050, 32'h0000F00F, 32'h12300000, 0, 0, 0);

    // 6: reset while waiting for the read response
    conf_op = OP_XOR; conf_enable = 1'b1;
    bus.s_valid = 1'b1; bus.s_addr = 16'h0060; bus.s_pixel = 32'h11111111;
    @(negedge aclk);
    bus.s_valid = 1'b0;
    bus.rd_req_ready = 1'b1;
    @(negedge aclk);
    bus.rd_req_ready = 1'b0;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge aclk);
    reset = 1'b0;
    exp_count = '0; exp_err = 1'b0;
    chk("midrst_s_ready", bus.s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_frag_count", frag_count, 0);
    chk("midrst_err", err_rsp, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("midrst_no_write", bus.m_valid, 0);
    end

    // Randomized fragments
    for (int n = 0; n < 40; n++) begin
      run_frag(4'($urandom), 1'($urandom_range(0, 3) != 0), AW'($urandom), $urandom, $urandom,
               $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
